// File: rtl/alu_seq_if.sv
// Request/response bundle between a requester and the multi-byte ALU sequencer.
interface alu_seq_if #(parameter int NBYTES = 4);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [8*NBYTES-1:0]   req_a;
  logic [8*NBYTES-1:0]   req_b;
  logic                  req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*NBYTES-1:0]   rsp_y;
  logic                  rsp_cout;
  logic                  rsp_zout;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_cout, rsp_zout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_cout, rsp_zout
  );
endinterface

// File: rtl/alu_seq.sv
// Runs one NBYTES-wide operation byte by byte through a shared 8-bit ALU.
// Define ALU_SEQ_VARLAT_EN to skip the ADD/SUB FIX cycle when nothing is pending.
module alu_seq #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_zout
);
  localparam int W = 8 * NBYTES;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b0101;
  localparam logic [3:0] OP_ROL = 4'b0110;

  typedef enum logic [1:0] {IDLE, STEP, FIX, DONE} state_t;

  state_t         state, state_nx;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q, b_q, y_q;
  logic [7:0]     partial_q;
  logic [2:0]     idx_q;
  logic           chain_q, c1_q, zacc_q;

  logic           is_arith, is_rot, last_byte, pend, skip_fix, commit;
  logic [1:0]     byte_sel;
  logic [7:0]     a_byte, b_byte;

  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_rot    = (op_q == OP_ROR) || (op_q == OP_ROL);
  assign last_byte = (idx_q == 3'(NBYTES - 1));
  // ROR walks the operand from the top byte down so the chain bit flows right.
  assign byte_sel  = (op_q == OP_ROR) ? 2'(NBYTES - 1 - int'(idx_q)) : idx_q[1:0];
  assign a_byte    = a_q[{byte_sel, 3'b000} +: 8];
  assign b_byte    = b_q[{byte_sel, 3'b000} +: 8];
  // chain_q holds carry for ADD but no-borrow for SUB, so "pending" flips sense.
  assign pend      = (op_q == OP_ADD) ? chain_q : ~chain_q;

`ifdef ALU_SEQ_VARLAT_EN
  assign skip_fix = ~pend;
`else
  assign skip_fix = 1'b0;
`endif

  assign commit = ((state == STEP) && (!is_arith || skip_fix)) || (state == FIX);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_cout  = chain_q & (is_arith | is_rot);
  assign bus.rsp_zout  = zacc_q;

  always_comb begin
    state_nx = state;
    alu_op   = 4'b0000;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) state_nx = STEP;
      STEP: begin
        alu_op  = op_q;
        alu_a   = a_byte;
        alu_b   = b_byte;
        alu_cin = is_rot ? chain_q : 1'b0;
        if (is_arith && !skip_fix) state_nx = FIX;
        else if (last_byte)        state_nx = DONE;
      end
      FIX: begin
        alu_op   = op_q;
        alu_a    = partial_q;
        alu_b    = {7'd0, pend};
        state_nx = last_byte ? DONE : STEP;
      end
      DONE: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      partial_q <= '0;
      idx_q     <= '0;
      chain_q   <= 1'b0;
      c1_q      <= 1'b0;
      zacc_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          a_q     <= bus.req_a;
          b_q     <= bus.req_b;
          chain_q <= bus.req_cin;
          idx_q   <= '0;
          zacc_q  <= 1'b1;
          y_q     <= '0;
        end
        STEP: begin
          if (is_arith && !skip_fix) begin
            partial_q <= alu_y;
            c1_q      <= alu_cout;
          end else if (is_arith || is_rot) begin
            chain_q <= alu_cout;
          end
        end
        // Byte and fix-up borrows combine as OR of borrows, i.e. AND of no-borrows.
        FIX: chain_q <= (op_q == OP_ADD) ? (c1_q | alu_cout) : (c1_q & alu_cout);
        default: ;
      endcase
      if (commit) begin
        y_q[{byte_sel, 3'b000} +: 8] <= alu_y;
        zacc_q <= zacc_q & alu_zout;
        idx_q  <= idx_q + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural 8-bit ALU and a response scoreboard.
module tb_alu_seq;
  localparam int NB = 4;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] y;
    logic        c;
    logic        z;
    int          lat_fix;
    int          lat_var;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic        c;
    logic        z;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_cin, alu_cout, alu_zout;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[15];

  alu_seq_if #(.NBYTES(NB)) bus ();

  alu_seq #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_y    (alu_y),
    .alu_cout (alu_cout),
    .alu_zout (alu_zout)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared 8-bit ALU.
  always_comb begin
    logic [8:0] sum;
    sum      = {1'b0, alu_a} + {1'b0, alu_b};
    alu_y    = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      4'b0000: begin alu_y = sum[7:0]; alu_cout = sum[8]; end
      4'b1000: begin alu_y = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
      4'b0001: alu_y = alu_a & alu_b;
      4'b0010: alu_y = alu_a | alu_b;
      4'b0011: alu_y = alu_a ^ alu_b;
      4'b0100: alu_y = ~alu_a;
      4'b0101: begin alu_y = {alu_cin, alu_a[7:1]}; alu_cout = alu_a[0]; end
      4'b0110: begin alu_y = {alu_a[6:0], alu_cin}; alu_cout = alu_a[7]; end
      4'b0111: alu_y = {alu_a[3:0], alu_a[7:4]};
      default: alu_y = 8'h00;
    endcase
    alu_zout = (alu_y == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    int   guard;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_cin   = v.cin;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    e.y = v.y;
    e.c = v.c;
    e.z = v.z;
`ifdef ALU_SEQ_VARLAT_EN
    e.lat = v.lat_var;
`else
    e.lat = v.lat_fix;
`endif
    sb.push_back(e);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic check_output(input int hold, input string tag);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!bus.rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, cyc, e.lat);
      check({tag, "_y"}, bus.rsp_y, e.y);
      check({tag, "_cout"}, {31'd0, bus.rsp_cout}, {31'd0, e.c});
      check({tag, "_zout"}, {31'd0, bus.rsp_zout}, {31'd0, e.z});
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_hold_y"}, bus.rsp_y, e.y);
        check({tag, "_hold_cout"}, {31'd0, bus.rsp_cout}, {31'd0, e.c});
        check({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_req_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    //          op       a             b             cin   y             c     z     Lf Lv
    vecs[0]  = '{4'h0, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0, 8, 7};
    vecs[1]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 8, 7};
    vecs[2]  = '{4'h0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 8, 5};
    vecs[3]  = '{4'h8, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 8, 7};
    vecs[4]  = '{4'h8, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b1, 8, 4};
    vecs[5]  = '{4'h6, 32'h80000001, 32'h00000000, 1'b1, 32'h00000003, 1'b1, 1'b0, 4, 4};
    vecs[6]  = '{4'h5, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 4, 4};
    vecs[7]  = '{4'h3, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'hF00FF00F, 1'b0, 1'b0, 4, 4};
    vecs[8]  = '{4'h1, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 32'h30303030, 1'b0, 1'b0, 4, 4};
    vecs[9]  = '{4'h4, 32'hA5A5A5A5, 32'h00000000, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 4, 4};
    vecs[10] = '{4'h7, 32'h12345678, 32'h00000000, 1'b0, 32'h21436587, 1'b0, 1'b0, 4, 4};
    vecs[11] = '{4'h2, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 4, 4};
    vecs[12] = '{4'h5, 32'h00000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 4, 4};
    vecs[13] = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000001, 1'b0, 1'b0, 8, 8};
    vecs[14] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b0, 1'b1, 4, 4};

    bus.req_valid = 1'b0;
    bus.req_op    = 4'h0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_y", bus.rsp_y, 32'd0);
    check("reset_rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
    check("reset_rsp_zout", {31'd0, bus.rsp_zout}, 32'd0);
    check("reset_alu_op", {28'd0, alu_op}, 32'd0);
    check("reset_alu_a", {24'd0, alu_a}, 32'd0);
    check("reset_alu_b", {24'd0, alu_b}, 32'd0);
    check("reset_alu_cin", {31'd0, alu_cin}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_output(0, $sformatf("v%0d", i));
    end

    // Stalled consumer, then a request right after the handshake.
    v = '{4'h0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 8, 6};
    apply_stimulus(v);
    check_output(5, "hold");
    v = '{4'h0, 32'h11111111, 32'h22222222, 1'b1, 32'h33333334, 1'b0, 1'b0, 8, 5};
    apply_stimulus(v);
    check_output(0, "b2b");

    // Reset in the third ALU cycle of an ADD.
    bus.req_op    = 4'h0;
    bus.req_a     = 32'h01010101;
    bus.req_b     = 32'h01010101;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("midop_alu_a", {24'd0, alu_a}, 32'h01);
    check("midop_req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_rsp_y", bus.rsp_y, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    v = '{4'h0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 8, 4};
    apply_stimulus(v);
    check_output(0, "post_rst_add");

    check("sb_empty_at_end", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
